// File: rtl/turbo_pkg.sv
// Shared types and default parameters for the turbo frame controller.
//   state_e : controller state encoding (LOAD, CLEAR, ENCODE, TAIL, DONE)
//   *_DEF   : default frame length, counter width, interleaver stride, tail length
package turbo_pkg;

    localparam int unsigned K_DEF    = 16;
    localparam int unsigned AW_DEF   = 4;
    localparam int unsigned P_DEF    = 5;
    localparam int unsigned TAIL_DEF = 3;

    typedef enum logic [2:0] {
        ST_LOAD   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_ENCODE = 3'd2,
        ST_TAIL   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/turbo_frame_ctrl_if.sv
// Handshake and encoder-control bundle of the turbo frame controller.
//   slave  : controller side (takes the serial source and out_ready, drives encoder controls)
//   master : environment side (drives the source and out_ready, observes the controls)
interface turbo_frame_ctrl_if;

    logic in_valid;
    logic in_bit;
    logic in_ready;
    logic out_ready;
    logic enc_clr;
    logic enc_en;
    logic enc_sys;
    logic enc_int;
    logic enc_tail;
    logic frame_start;
    logic frame_done;
    logic busy;

    modport slave (
        input  in_valid, in_bit, out_ready,
        output in_ready, enc_clr, enc_en, enc_sys, enc_int, enc_tail,
               frame_start, frame_done, busy
    );

    modport master (
        output in_valid, in_bit, out_ready,
        input  in_ready, enc_clr, enc_en, enc_sys, enc_int, enc_tail,
               frame_start, frame_done, busy
    );

endinterface

// File: rtl/turbo_il_addr.sv
// Interleaver address generator: addr walks 0, P, 2P, ... modulo K.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : restart the sequence at 0 (has priority over step)
//   step     : advance to (addr + P) mod K
//   addr     : current interleaved read address
module turbo_il_addr
    import turbo_pkg::*;
#(
    parameter int unsigned K  = K_DEF,
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned P  = P_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          step,
    output logic [AW-1:0] addr
);

    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_d;
    logic [AW:0]   sum;

    // One extra bit on the sum so addr + P cannot overflow before the K compare.
    always_comb begin
        sum    = {1'b0, addr_q} + (AW+1)'(P);
        addr_d = addr_q;
        if (clr) begin
            addr_d = '0;
        end else if (step) begin
            if (sum >= (AW+1)'(K)) begin
                addr_d = AW'(sum - (AW+1)'(K));
            end else begin
                addr_d = sum[AW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr = addr_q;

endmodule

// File: rtl/turbo_frame_ctrl.sv
// Frame sequencer for the turbo encoder: loads K bits serially, clears the
// encoder, streams natural/interleaved bits to the two constituent encoders,
// runs TAIL termination steps and pulses frame_done.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : slave side of turbo_frame_ctrl_if (source handshake, out_ready,
//              encoder controls, frame_start/frame_done/busy)
// Outputs are decoded from registered state; only enc_en follows out_ready
// directly. in_ready is gated by rst so it drops immediately in reset.
module turbo_frame_ctrl
    import turbo_pkg::*;
#(
    parameter int unsigned K    = K_DEF,
    parameter int unsigned AW   = AW_DEF,
    parameter int unsigned P    = P_DEF,
    parameter int unsigned TAIL = TAIL_DEF
) (
    input  logic             clk,
    input  logic             rst,
    turbo_frame_ctrl_if.slave bus
);

    localparam int unsigned TW = (TAIL > 1) ? $clog2(TAIL) : 1;

    state_e        state_q, state_d;
    logic [AW-1:0] wcnt_q, wcnt_d;
    logic [AW-1:0] rcnt_q, rcnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [K-1:0]  fbuf_q, fbuf_d;

    logic [AW-1:0] iaddr;
    logic          il_clr;
    logic          il_step;

    logic in_ready, enc_clr, enc_en, enc_sys, enc_int, enc_tail;
    logic frame_start, frame_done, busy;

    turbo_il_addr #(
        .K  (K),
        .AW (AW),
        .P  (P)
    ) u_il_addr (
        .clk  (clk),
        .rst  (rst),
        .clr  (il_clr),
        .step (il_step),
        .addr (iaddr)
    );

    // Next-state, counter/buffer updates and output decode.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        tcnt_d      = tcnt_q;
        fbuf_d      = fbuf_q;
        il_clr      = 1'b0;
        il_step     = 1'b0;
        in_ready    = 1'b0;
        enc_clr     = 1'b0;
        enc_en      = 1'b0;
        enc_sys     = 1'b0;
        enc_int     = 1'b0;
        enc_tail    = 1'b0;
        frame_start = 1'b0;
        frame_done  = 1'b0;
        busy        = 1'b0;

        unique case (state_q)
            ST_LOAD: begin
                in_ready = rst;
                if (bus.in_valid && rst) begin
                    fbuf_d[wcnt_q] = bus.in_bit;
                    if (wcnt_q == AW'(K-1)) begin
                        wcnt_d  = '0;
                        state_d = ST_CLEAR;
                    end else begin
                        wcnt_d = wcnt_q + AW'(1);
                    end
                end
            end
            ST_CLEAR: begin
                enc_clr     = 1'b1;
                frame_start = 1'b1;
                busy        = 1'b1;
                rcnt_d      = '0;
                il_clr      = 1'b1;
                state_d     = ST_ENCODE;
            end
            ST_ENCODE: begin
                busy    = 1'b1;
                enc_sys = fbuf_q[rcnt_q];
                enc_int = fbuf_q[iaddr];
                enc_en  = bus.out_ready;
                if (bus.out_ready) begin
                    il_step = 1'b1;
                    rcnt_d  = rcnt_q + AW'(1);
                    if (rcnt_q == AW'(K-1)) begin
                        tcnt_d  = '0;
                        state_d = ST_TAIL;
                    end
                end
            end
            ST_TAIL: begin
                busy     = 1'b1;
                enc_tail = 1'b1;
                enc_en   = bus.out_ready;
                if (bus.out_ready) begin
                    tcnt_d = tcnt_q + TW'(1);
                    if (tcnt_q == TW'(TAIL-1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                busy       = 1'b1;
                frame_done = 1'b1;
                state_d    = ST_LOAD;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_LOAD;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            tcnt_q  <= '0;
            fbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            tcnt_q  <= tcnt_d;
            fbuf_q  <= fbuf_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.enc_clr     = enc_clr;
    assign bus.enc_en      = enc_en;
    assign bus.enc_sys     = enc_sys;
    assign bus.enc_int     = enc_int;
    assign bus.enc_tail    = enc_tail;
    assign bus.frame_start = frame_start;
    assign bus.frame_done  = frame_done;
    assign bus.busy        = busy;

endmodule
